// File: rtl/i2c_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// i2c_cfg_sequencer
//
// Walks a combinational configuration table once after power-up and issues
// one byte-write request per entry to an external I2C engine. NACKed entries
// are re-issued up to MAX_RETRY times; an entry that still fails is skipped,
// counted in err_cnt, and flagged via the sticky cfg_err. A cfg_start pulse
// in DONE replays the whole table without the power-up wait.
//
// Ports
//   clk, rst_n         : clock (rising edge), synchronous active-low reset
//   cfg_start          : replay pulse, honoured only in DONE
//   lut_index          : table address to the config LUT
//   lut_data           : {dev_addr, reg_addr, wdata} for lut_index
//   lut_size           : number of valid table entries
//   i2c_req            : one-cycle write request to the I2C engine
//   i2c_dev_addr/_reg_addr/_wdata : registered transaction fields
//   i2c_done, i2c_nack : completion pulse, NACK flag qualified by i2c_done
//   cfg_done           : high while the table has been fully processed
//   cfg_err            : sticky, some entry exhausted its retries
//   err_cnt            : skipped entries, saturating at 255
//   state_dbg          : current FSM state encoding
//
// Handshake: i2c_req is a single-cycle pulse; the fields are stable from the
// LOAD cycle until the next LOAD. The engine answers each request with exactly
// one i2c_done pulse; i2c_nack is only meaningful in the i2c_done cycle and
// is ignored otherwise. There is no backpressure on i2c_req.
// -----------------------------------------------------------------------------
module i2c_cfg_sequencer #(
  parameter logic [19:0] INIT_DELAY = 20'd1000000,
  parameter logic [15:0] GAP_CYCLES = 16'd500,
  parameter int          MAX_RETRY  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_start,
  output logic [8:0]  lut_index,
  input  logic [23:0] lut_data,
  input  logic [8:0]  lut_size,
  output logic        i2c_req,
  output logic [7:0]  i2c_dev_addr,
  output logic [7:0]  i2c_reg_addr,
  output logic [7:0]  i2c_wdata,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [7:0]  err_cnt,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    INIT_WAIT = 3'd0,
    LOAD      = 3'd1,
    REQ       = 3'd2,
    WAIT_ACK  = 3'd3,
    GAP       = 3'd4,
    DONE      = 3'd5
  } state_t;

  localparam logic [3:0] MAX_RETRY_L = 4'(MAX_RETRY);

  state_t      state, state_d;
  logic [19:0] init_cnt, init_cnt_d;
  logic [15:0] gap_cnt, gap_cnt_d;
  logic [3:0]  retry, retry_d;
  logic        advance, advance_d;
  logic [8:0]  idx_d;
  logic [7:0]  dev_d, reg_d, wdata_d;
  logic        err_d;
  logic [7:0]  err_cnt_d;

  // Widened compares so a zero parameter or a zero/shrunk lut_size never
  // wraps: GAP exits after max(GAP_CYCLES,1) cycles, and the pass ends as
  // soon as the next index would fall outside the current table.
  logic gap_last;
  logic idx_last;
  assign gap_last = ({1'b0, gap_cnt} + 17'd1) >= {1'b0, GAP_CYCLES};
  assign idx_last = ({1'b0, lut_index} + 10'd1) >= {1'b0, lut_size};

  always_comb begin
    state_d    = state;
    init_cnt_d = init_cnt;
    gap_cnt_d  = gap_cnt;
    retry_d    = retry;
    advance_d  = advance;
    idx_d      = lut_index;
    dev_d      = i2c_dev_addr;
    reg_d      = i2c_reg_addr;
    wdata_d    = i2c_wdata;
    err_d      = cfg_err;
    err_cnt_d  = err_cnt;

    case (state)
      INIT_WAIT: begin
        if (init_cnt >= INIT_DELAY) begin
          init_cnt_d = '0;
          idx_d      = '0;
          state_d    = (lut_size == 9'd0) ? DONE : LOAD;
        end else begin
          init_cnt_d = init_cnt + 20'd1;
        end
      end
      LOAD: begin
        // One full cycle with lut_index stable lets the LUT settle first.
        dev_d   = lut_data[23:16];
        reg_d   = lut_data[15:8];
        wdata_d = lut_data[7:0];
        state_d = REQ;
      end
      REQ: begin
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (i2c_done) begin
          gap_cnt_d = '0;
          state_d   = GAP;
          if (!i2c_nack) begin
            retry_d   = '0;
            advance_d = 1'b1;
          end else if (retry < MAX_RETRY_L) begin
            retry_d   = retry + 4'd1;
            advance_d = 1'b0;
          end else begin
            err_d     = 1'b1;
            err_cnt_d = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
            retry_d   = '0;
            advance_d = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_last) begin
          gap_cnt_d = '0;
          if (advance && idx_last) begin
            state_d = DONE;
          end else begin
            if (advance) idx_d = lut_index + 9'd1;
            state_d = LOAD;
          end
        end else begin
          gap_cnt_d = gap_cnt + 16'd1;
        end
      end
      DONE: begin
        if (cfg_start) begin
          idx_d     = '0;
          retry_d   = '0;
          err_d     = 1'b0;
          err_cnt_d = '0;
          // An empty table has nothing to replay; stay finished.
          state_d   = (lut_size == 9'd0) ? DONE : LOAD;
        end
      end
      default: state_d = INIT_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= INIT_WAIT;
      init_cnt     <= '0;
      gap_cnt      <= '0;
      retry        <= '0;
      advance      <= 1'b0;
      lut_index    <= '0;
      i2c_dev_addr <= '0;
      i2c_reg_addr <= '0;
      i2c_wdata    <= '0;
      cfg_err      <= 1'b0;
      err_cnt      <= '0;
    end else begin
      state        <= state_d;
      init_cnt     <= init_cnt_d;
      gap_cnt      <= gap_cnt_d;
      retry        <= retry_d;
      advance      <= advance_d;
      lut_index    <= idx_d;
      i2c_dev_addr <= dev_d;
      i2c_reg_addr <= reg_d;
      i2c_wdata    <= wdata_d;
      cfg_err      <= err_d;
      err_cnt      <= err_cnt_d;
    end
  end

  assign i2c_req   = (state == REQ);
  assign cfg_done  = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for i2c_cfg_sequencer with INIT_DELAY=10, GAP_CYCLES=4, MAX_RETRY=2.
// A responder answers each request RESP_LAT cycles later with ACK/NACK from a
// per-entry NACK plan. The model predicts the full list of requests (cycle,
// index, fields) and the cfg_done cycle for a pass from the timing rules:
// first request two cycles after the LOAD point, one request every
// RESP_LAT+GAP+2 cycles, each entry tried min(nacks,MAX_RETRY)+1 times.
// -----------------------------------------------------------------------------
module tb_i2c_cfg_sequencer;

  localparam logic [19:0] INIT_DELAY = 20'd10;
  localparam logic [15:0] GAP        = 16'd4;
  localparam int          MAX_RETRY  = 2;
  localparam int          RESP_LAT   = 5;
  localparam int          W          = 49;

  logic        clk, rst_n, cfg_start;
  logic [8:0]  lut_index;
  logic [23:0] lut_data;
  logic [8:0]  lut_size;
  logic        i2c_req;
  logic [7:0]  i2c_dev_addr, i2c_reg_addr, i2c_wdata;
  logic        i2c_done, i2c_nack;
  logic        cfg_done, cfg_err;
  logic [7:0]  err_cnt;
  logic [2:0]  state_dbg;

  i2c_cfg_sequencer #(
    .INIT_DELAY(INIT_DELAY),
    .GAP_CYCLES(GAP),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_start   (cfg_start),
    .lut_index   (lut_index),
    .lut_data    (lut_data),
    .lut_size    (lut_size),
    .i2c_req     (i2c_req),
    .i2c_dev_addr(i2c_dev_addr),
    .i2c_reg_addr(i2c_reg_addr),
    .i2c_wdata   (i2c_wdata),
    .i2c_done    (i2c_done),
    .i2c_nack    (i2c_nack),
    .cfg_done    (cfg_done),
    .cfg_err     (cfg_err),
    .err_cnt     (err_cnt),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // ---------------- table and responder ----------------
  logic [23:0] lut_mem [0:15];
  int          nack_plan [0:15];
  int          attempts [0:15];
  assign lut_data = lut_mem[lut_index[3:0]];

  logic resp_en, stray_nack;
  int   resp_idx;

  initial begin
    i2c_done = 1'b0;
    i2c_nack = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_en && i2c_req) begin
        resp_idx = int'(lut_index[3:0]);
        repeat (2) @(negedge clk);
        i2c_nack = stray_nack;
        @(negedge clk);
        i2c_nack = 1'b0;
        repeat (2) @(negedge clk);
        i2c_done = 1'b1;
        i2c_nack = (attempts[resp_idx] < nack_plan[resp_idx]);
        attempts[resp_idx]++;
        @(negedge clk);
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
      end
    end
  end

  // ---------------- scoreboard / model ----------------
  logic [W-1:0] exp_q[$];
  int exp_done_cyc;
  int exp_err;
  int checks, failures;
  logic mon_en;
  int log_idx[$];
  int log_cyc[$];
  int done_seen;
  int exp_seq[];

  task automatic model_pass(input int first_req, input int size);
    int t, last, n;
    logic [15:0] tc;
    exp_q.delete();
    exp_err = 0;
    if (size == 0) begin
      exp_done_cyc = first_req - 1;
    end else begin
      t = first_req;
      last = t;
      for (int i = 0; i < size; i++) begin
        n = ((nack_plan[i] < MAX_RETRY) ? nack_plan[i] : MAX_RETRY) + 1;
        if (nack_plan[i] > MAX_RETRY) exp_err++;
        for (int a = 0; a < n; a++) begin
          tc = t[15:0];
          exp_q.push_back({tc, 9'(i), lut_mem[i]});
          last = t;
          t = t + RESP_LAT + int'(GAP) + 2;
        end
      end
      exp_done_cyc = last + RESP_LAT + 1 + int'(GAP);
    end
  endtask

  always begin
    logic [W-1:0] act, e;
    @(posedge clk);
    #1;
    if (mon_en) begin
      checks++;
      if (cfg_done !== (cyc >= exp_done_cyc)) begin
        failures++;
        $display("FAIL cfg_done cyc=%0d actual=%0b required=%0b", cyc, cfg_done, (cyc >= exp_done_cyc));
      end
      if (cfg_done && done_seen < 0) done_seen = cyc;
      if (i2c_req) begin
        log_idx.push_back(int'(lut_index));
        log_cyc.push_back(cyc);
        act = {cyc[15:0], lut_index, i2c_dev_addr, i2c_reg_addr, i2c_wdata};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL req_unexpected cyc=%0d actual_idx=%0d required=none", cyc, lut_index);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            failures++;
            $display("FAIL req_record actual=%h required=%h (cyc|idx|dev|reg|wdata)", act, e);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0][48:33] == cyc[15:0]) begin
        checks++;
        failures++;
        $display("FAIL req_missing cyc=%0d actual=no_req required=%h", cyc, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic check_seq(input string name);
    check({name, "_len"}, log_idx.size(), exp_seq.size());
    for (int i = 0; i < exp_seq.size() && i < log_idx.size(); i++)
      check({name, "_idx"}, log_idx[i], exp_seq[i]);
  endtask

  task automatic clear_logs();
    log_idx.delete();
    log_cyc.delete();
    done_seen = -1;
    for (int i = 0; i < 16; i++) attempts[i] = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_after_reset();
    mon_en = 1'b0;
    pulse_reset();
    clear_logs();
    model_pass(int'(INIT_DELAY) + 2, int'(lut_size));
    mon_en = 1'b1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while (!cfg_done && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!cfg_done) begin
      failures++;
      $display("FAIL %s_timeout actual=cfg_done_low required=cfg_done_high", name);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_req"},   int'(i2c_req), 0);
    check({name, "_index"}, int'(lut_index), 0);
    check({name, "_fields"}, int'({i2c_dev_addr, i2c_reg_addr, i2c_wdata}), 0);
    check({name, "_done"},  int'(cfg_done), 0);
    check({name, "_err"},   int'(cfg_err), 0);
    check({name, "_errcnt"}, int'(err_cnt), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int s, k;
    rst_n = 1'b0; cfg_start = 1'b0; resp_en = 1'b1; stray_nack = 1'b0;
    mon_en = 1'b0; checks = 0; failures = 0; exp_done_cyc = 1 << 30;
    exp_err = 0; done_seen = -1;
    for (int i = 0; i < 16; i++) begin
      lut_mem[i] = 24'hA00000 + 24'(i * 24'h010203);
      nack_plan[i] = 0;
      attempts[i] = 0;
    end
    lut_mem[0] = 24'h4A105C;
    lut_mem[1] = 24'h4A11A3;
    lut_mem[2] = 24'h213F07;
    lut_size = 9'd3;
    repeat (3) @(negedge clk);

    // Clean pass, with a stray NACK (no done) inside each WAIT_ACK.
    stray_nack = 1'b1;
    start_after_reset();
    check_reset_state("rst");
    wait_done("t1", 300);
    stray_nack = 1'b0;
    check("t1_nreq", log_cyc.size(), 3);
    if (log_cyc.size() > 0) check("t1_first_req_cyc", log_cyc[0], 12);
    check("t1_done_cyc", done_seen, 44);
    exp_seq = '{0, 1, 2};
    check_seq("t1_seq");
    check("t1_err", int'(cfg_err), 0);
    check("t1_errcnt", int'(err_cnt), 0);
    check("t1_leftover", exp_q.size(), 0);

    // Entry 1 NACKs once then ACKs.
    nack_plan[1] = 1;
    start_after_reset();
    wait_done("t2", 300);
    exp_seq = '{0, 1, 1, 2};
    check_seq("t2_seq");
    check("t2_err", int'(cfg_err), exp_err);
    check("t2_errcnt", int'(err_cnt), 0);
    check("t2_leftover", exp_q.size(), 0);

    // Entry 1 always NACKs: retried MAX_RETRY times, then skipped.
    nack_plan[1] = 99;
    start_after_reset();
    wait_done("t3", 400);
    exp_seq = '{0, 1, 1, 1, 2};
    check_seq("t3_seq");
    check("t3_err", int'(cfg_err), 1);
    check("t3_errcnt", int'(err_cnt), exp_err);
    check("t3_done", int'(cfg_done), 1);
    check("t3_leftover", exp_q.size(), 0);

    // Replay from DONE, then a mid-pass cfg_start that must be ignored.
    clear_logs();
    s = cyc;
    cfg_start = 1'b1;
    model_pass(s + 2, int'(lut_size));
    @(negedge clk);
    cfg_start = 1'b0;
    check("t6_err_clr", int'(cfg_err), 0);
    check("t6_errcnt_clr", int'(err_cnt), 0);
    check("t6_done_clr", int'(cfg_done), 0);
    repeat (15) @(negedge clk);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    wait_done("t6", 400);
    if (log_cyc.size() > 0) check("t6_first_req_lat", log_cyc[0] - s, 2);
    check_seq("t6_seq");
    check("t6_err", int'(cfg_err), 1);
    check("t6_errcnt", int'(err_cnt), 1);
    check("t6_leftover", exp_q.size(), 0);

    // Empty table: straight to DONE after the power-up wait.
    nack_plan[1] = 0;
    lut_size = 9'd0;
    start_after_reset();
    wait_done("t4", 100);
    check("t4_nreq", log_cyc.size(), 0);
    check("t4_done_cyc", done_seen, 11);

    // Reset in WAIT_ACK, followed by a stale i2c_done.
    lut_size = 9'd3;
    resp_en = 1'b0;
    mon_en = 1'b0;
    pulse_reset();
    k = 0;
    while (!i2c_req && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("t5_req_seen", int'(i2c_req), 1);
    repeat (2) @(negedge clk);
    pulse_reset();
    clear_logs();
    model_pass(int'(INIT_DELAY) + 2, int'(lut_size));
    mon_en = 1'b1;
    check_reset_state("t5_rst");
    i2c_done = 1'b1;
    @(negedge clk);
    i2c_done = 1'b0;
    check("t5_req_after", int'(i2c_req), 0);
    check("t5_index_after", int'(lut_index), 0);
    resp_en = 1'b1;
    wait_done("t5", 300);
    if (log_cyc.size() > 0) check("t5_first_req_cyc", log_cyc[0], 12);
    exp_seq = '{0, 1, 2};
    check_seq("t5_seq");
    check("t5_leftover", exp_q.size(), 0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_cfg_sequencer.md
I2C_CFG_SEQUENCER -- requirements
Module: i2c_cfg_sequencer

Interface
REQ-001 SHALL have parameter INIT_DELAY, default 20'd1000000: power-up wait in clk cycles before the first transaction (20 ms at 50 MHz).
REQ-002 SHALL have parameter GAP_CYCLES, default 16'd500: idle clk cycles between consecutive transactions.
REQ-003 SHALL have parameter MAX_RETRY, default 3: maximum re-issues of one entry after NACK.
REQ-004 SHALL have port clk, input, 1: sole clock; all logic rising-edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port cfg_start, input, 1: single-cycle pulse that re-runs the whole table from index 0; honoured only in DONE.
REQ-007 SHALL have port lut_index, output, 9: table address driven to the combinational config LUT.
REQ-008 SHALL have port lut_data, input, 24: {dev_addr[23:16], reg_addr[15:8], wdata[7:0]} for lut_index.
REQ-009 SHALL have port lut_size, input, 9: number of valid entries.
REQ-010 SHALL have port i2c_req, output, 1: write request to the byte-write I2C engine.
REQ-011 SHALL have ports i2c_dev_addr, i2c_reg_addr, i2c_wdata, output, 8 each: registered transaction fields.
REQ-012 SHALL have port i2c_done, input, 1: single-cycle pulse, transaction finished.
REQ-013 SHALL have port i2c_nack, input, 1: qualified by i2c_done; 1 = slave did not ACK.
REQ-014 SHALL have port cfg_done, output, 1: high while in DONE.
REQ-015 SHALL have port cfg_err, output, 1: sticky; set when any entry exhausts retries.
REQ-016 SHALL have port err_cnt, output, 8: number of skipped entries, saturating at 255.

Function
REQ-017 SHALL implement states INIT_WAIT, LOAD, REQ, WAIT_ACK, GAP, DONE.
REQ-018 INIT_WAIT SHALL count INIT_DELAY cycles, then go to LOAD with lut_index=0; if lut_size==0, go to DONE instead.
REQ-019 LOAD SHALL last exactly one cycle and latch lut_data into i2c_dev_addr/i2c_reg_addr/i2c_wdata, so the combinational LUT settles before capture.
REQ-020 REQ SHALL assert i2c_req for exactly one cycle, then enter WAIT_ACK.
REQ-021 i2c_req SHALL never be asserted outside REQ; transaction fields SHALL remain stable from LOAD until the next LOAD.
REQ-022 WAIT_ACK SHALL wait indefinitely for i2c_done; an i2c_nack without i2c_done SHALL be ignored.
REQ-023 On i2c_done with i2c_nack=0, the block SHALL clear the retry counter and go to GAP with the advance flag set.
REQ-024 On i2c_done with i2c_nack=1 and retry<MAX_RETRY, the block SHALL increment retry and go to GAP with the advance flag clear, so the same entry is re-issued.
REQ-025 On i2c_done with i2c_nack=1 and retry==MAX_RETRY, the block SHALL set cfg_err, increment err_cnt (saturating), clear retry and go to GAP with the advance flag set.
REQ-026 GAP SHALL count GAP_CYCLES cycles; if advancing and lut_index==lut_size-1 it SHALL go to DONE, else it SHALL increment lut_index when advancing and go to LOAD.
REQ-027 Transaction count per pass SHALL be lut_size plus total retries; index SHALL never exceed lut_size-1.
REQ-028 In DONE, cfg_start SHALL clear lut_index, retry, cfg_err and err_cnt and go to LOAD with no INIT_DELAY; cfg_start in any other state SHALL be ignored.
REQ-029 lut_size SHALL be sampled at each GAP exit; a change mid-pass takes effect at the next comparison.
REQ-030 Counters SHALL be wide enough for parameter maxima without wrap: 20-bit init, 16-bit gap, 4-bit retry.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force INIT_WAIT with lut_index=0, i2c_req=0, fields=0, cfg_done=0, cfg_err=0, err_cnt=0, all counters 0, from any state including WAIT_ACK.
REQ-032 After reset, an i2c_done arriving for an aborted transaction SHALL be ignored, because INIT_WAIT does not sample it.

Verification (INIT_DELAY=10, GAP_CYCLES=4, MAX_RETRY=2)
REQ-033 lut_size=3, all ACK, i2c_done 5 cycles after each i2c_req -> first i2c_req at cycle 12 after reset release; exactly 3 requests with indices 0,1,2 and matching fields; cfg_done=1; cfg_err=0.
REQ-034 Entry 1 NACKs once then ACKs -> 4 requests with index sequence 0,1,1,2; err_cnt=0; cfg_err=0.
REQ-035 Entry 1 always NACKs -> index sequence 0,1,1,1,2; cfg_err=1; err_cnt=1; cfg_done=1.
REQ-036 lut_size=0 -> no i2c_req; cfg_done=1 at INIT_DELAY+1 cycles.
REQ-037 rst_n pulsed low in WAIT_ACK, then a stale i2c_done pulse -> state is INIT_WAIT, i2c_req=0, full pass restarts from index 0.
REQ-038 cfg_start pulsed in DONE after an error pass -> cfg_err and err_cnt clear; i2c_req for index 0 follows within 2 cycles; cfg_start pulsed mid-pass -> no effect.
